sliced_ripple_adder: RTL and testbench
======================================

Name: sliced_ripple_adder

Overview:
- Parametrised multi-cycle adder/subtractor; successor to the combinational 4-bit ripple-carry adder.
- Adds two WIDTH-bit operands one SLICE-bit chunk per clock, LSB slice first, carrying between slices in a register.
- Trades latency for a short carry chain, which keeps timing on wide operands in the Spartan-3 clock design.
- Valid/ready handshakes on input and output; supports subtraction and reports signed overflow.

Parameters:
- WIDTH, 16, operand and result width in bits.
- SLICE, 4, bits added per cycle. Must divide WIDTH exactly. NSLICE = WIDTH/SLICE.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and mode present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c_in  in  1  carry-in.
- sub  in  1  1 = compute A - B (two's complement); 0 = add.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- c_out  out  1  carry out of MSB (for subtraction, 1 = no borrow).
- ovf  out  1  signed overflow.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; slice index = 0; carry = 0.
  - sum = 0, c_out = 0, ovf = 0, out_valid = 0, in_ready = 1 once released.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch a into opA and (sub ? ~b : b) into opB; carry = c_in ^ sub; idx = 0; go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle: {carry, sum[idx]} = opA[idx] + opB[idx] + carry, where [idx] denotes slice idx.
  - On the last slice, also record the carry into the MSB, for overflow.
  - When idx = NSLICE-1: go to DONE; else idx += 1.
- DONE:
  - out_valid = 1.
  - c_out = final carry; ovf = carry-into-MSB XOR carry-out.
  - sum, c_out and ovf stay stable until out_ready = 1; then go to IDLE in the following cycle.
  - in_ready = 0 throughout DONE: no overlap of operations.
- Latency:
  - Accepting edge at cycle t; out_valid high from the edge at t+NSLICE.
  - Minimum issue interval is NSLICE+2 cycles with out_ready held at 1.
- Timing of outputs:
  - sum is undefined (partial) while in RUN; only meaningful when out_valid = 1.
  - c_out and ovf are updated only on entry to DONE.
- Width rule: arithmetic is modulo 2^WIDTH. The carry register is 1 bit. Each slice adder is SLICE+1 bits wide.
- NSLICE = 1: RUN lasts one cycle, so the block behaves as a registered single-cycle adder.
- Holding inputs: in_valid held after acceptance is ignored until the block returns to IDLE. Operands are sampled only on the accept edge.
- Reset mid-operation: abandons the operation immediately; no out_valid is produced for it.
- Illegal parameters: WIDTH % SLICE != 0 is a parameter error, flagged in elaboration.

Decomposition:
- Shared package holds the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a function computing NSLICE and the index width as clog2(NSLICE), minimum 1.
- One natural sub-module: slice_adder.
  - Combinational SLICE-bit ripple adder.
  - Inputs a, b, cin; outputs s, cout, c_msb (carry into the top bit, for overflow).
  - Instantiated once and shared across cycles via muxing on idx.

Test Plan:
- WIDTH=16, SLICE=4: a=0x0005, b=0x0007, c_in=0, sub=0 -> sum=0x000C, c_out=0, ovf=0; out_valid exactly 4 edges after accept.
- a=0xFFFF, b=0xFFFF, c_in=1, sub=0 -> sum=0xFFFF, c_out=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, c_out=0.
- sub=1: a=0x0005, b=0x0007, c_in=0 -> sum=0xFFFE, c_out=0, ovf=0. Then a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1, c_out=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> sum, c_out and ovf stable, in_ready=0, a new in_valid is ignored. Release -> IDLE next cycle, then the second operation completes correctly.
- Reset mid-operation: assert rst_n=0 two cycles into RUN -> all outputs 0 immediately. After release, in_ready=1 and no stale out_valid appears.
- WIDTH=4, SLICE=4: 5+7 -> sum=0xC, c_out=0. 0xF+0xA with c_in=1 -> sum=0xA, c_out=1. Both with a latency of 1 edge.

Source files
------------

// File: rtl/sliced_ripple_adder_pkg.sv
// Shared types for the sliced ripple adder.
// FSM encoding and slice-count helpers.
package sliced_ripple_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int nslice(input int width, input int slice);
      return width / slice;
   endfunction

   // Index width for NSLICE slices, never below one bit.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sliced_ripple_adder_slice.sv
// Combinational SLICE-bit ripple adder.
// a, b, cin -> s, cout, c_msb (carry into top bit).
module sliced_ripple_adder_slice #(
   parameter int SLICE = 4
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             cin,
   output logic [SLICE-1:0] s,
   output logic             cout,
   output logic             c_msb
);

   logic [SLICE:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = cin;
      for (int i = 0; i < SLICE; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout  = c[SLICE];
   assign c_msb = c[SLICE-1];

endmodule

// File: rtl/sliced_ripple_adder.sv
// Multi-cycle add/sub, one SLICE per clock, LSB first.
// in: valid/ready a,b,c_in,sub; out: valid/ready sum,c_out,ovf.
module sliced_ripple_adder
   import sliced_ripple_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int NSLICE = nslice(WIDTH, SLICE);
   localparam int IDXW   = idx_width(NSLICE);
   localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

   if (WIDTH % SLICE != 0) begin : g_bad_param
      $error("WIDTH must be a multiple of SLICE");
   end

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  opa_q, opb_q, sum_q;
   logic [IDXW-1:0]   idx_q;
   logic              carry_q, c_out_q, ovf_q;
   logic [SLICE-1:0]  sl_a, sl_b, sl_s;
   logic              sl_cout, sl_cmsb;
   logic              last;

   assign last = (idx_q == LAST);
   assign sl_a = opa_q[idx_q*SLICE +: SLICE];
   assign sl_b = opb_q[idx_q*SLICE +: SLICE];

   sliced_ripple_adder_slice #(
      .SLICE (SLICE)
   ) u_slice (
      .a     (sl_a),
      .b     (sl_b),
      .cin   (carry_q),
      .s     (sl_s),
      .cout  (sl_cout),
      .c_msb (sl_cmsb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            if (last) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opa_q   <= '0;
         opb_q   <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         if (state_q == IDLE && in_valid) begin
            opa_q   <= a;
            // Subtraction is A + ~B + 1; the +1 rides in on the carry.
            opb_q   <= sub ? ~b : b;
            carry_q <= c_in ^ sub;
            idx_q   <= '0;
         end
         if (state_q == RUN) begin
            sum_q[idx_q*SLICE +: SLICE] <= sl_s;
            carry_q <= sl_cout;
            if (last) begin
               c_out_q <= sl_cout;
               ovf_q   <= sl_cmsb ^ sl_cout;
            end else begin
               idx_q <= idx_q + IDXW'(1);
            end
         end
      end
   end

   assign sum   = sum_q;
   assign c_out = c_out_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_sliced_ripple_adder.sv
// Bench for sliced_ripple_adder (16/4 and 4/4 builds).
// Arithmetic reference model, directed plus random ops.
module tb_sliced_ripple_adder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        iv16 = 0, ir16, ov16, or16 = 1, ci16 = 0, sb16 = 0;
   logic [15:0] a16 = 0, b16 = 0, s16;
   logic        co16, of16;

   logic        iv4 = 0, ir4, ov4, or4 = 1, ci4 = 0, sb4 = 0;
   logic [3:0]  a4 = 0, b4 = 0, s4;
   logic        co4, of4;

   int checks = 0;
   int errors = 0;

   sliced_ripple_adder #(.WIDTH(16), .SLICE(4)) u16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv16), .in_ready(ir16),
      .a(a16), .b(b16), .c_in(ci16), .sub(sb16),
      .out_valid(ov16), .out_ready(or16),
      .sum(s16), .c_out(co16), .ovf(of16)
   );

   sliced_ripple_adder #(.WIDTH(4), .SLICE(4)) u4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv4), .in_ready(ir4),
      .a(a4), .b(b4), .c_in(ci4), .sub(sb4),
      .out_valid(ov4), .out_ready(or4),
      .sum(s4), .c_out(co4), .ovf(of4)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Plain integer arithmetic: modular sum, carry bit, and
   // signed range check for overflow.
   task automatic model(input int w, input longint a, b,
                        input bit ci, su,
                        output longint s, output bit co, ov);
      longint m, bb, t, sa, sbb, r;
      m   = (64'sd1 << w) - 1;
      bb  = su ? (~b & m) : b;
      t   = a + bb + longint'(ci ^ su);
      s   = t & m;
      co  = ((t >> w) & 1) != 0;
      sa  = (a  >= (64'sd1 << (w-1))) ? a  - (64'sd1 << w) : a;
      sbb = (bb >= (64'sd1 << (w-1))) ? bb - (64'sd1 << w) : bb;
      r   = sa + sbb + longint'(ci ^ su);
      ov  = (r > (64'sd1 << (w-1)) - 1) || (r < -(64'sd1 << (w-1)));
   endtask

   function automatic logic o_val(bit n4);
      return n4 ? ov4 : ov16;
   endfunction
   function automatic logic o_rdy(bit n4);
      return n4 ? ir4 : ir16;
   endfunction
   function automatic logic [15:0] o_sum(bit n4);
      return n4 ? {12'h0, s4} : s16;
   endfunction
   function automatic logic o_co(bit n4);
      return n4 ? co4 : co16;
   endfunction
   function automatic logic o_of(bit n4);
      return n4 ? of4 : of16;
   endfunction

   task automatic drive(input bit n4, input bit v,
                        input logic [15:0] a, b,
                        input logic ci, su);
      if (n4) begin
         iv4 = v; a4 = a[3:0]; b4 = b[3:0]; ci4 = ci; sb4 = su;
      end else begin
         iv16 = v; a16 = a; b16 = b; ci16 = ci; sb16 = su;
      end
   endtask

   // Called at posedge+1; one full transaction with hold
   // cycles of backpressure in DONE.
   task automatic run_op(input bit n4, input logic [15:0] a, b,
                         input logic ci, su, input int hold);
      int     ns, w, k;
      longint es;
      bit     eco, eov;
      ns = n4 ? 1 : 4;
      w  = n4 ? 4 : 16;
      k  = 0;
      while (!o_rdy(n4) && k < 20) begin
         @(posedge clk); #1; k++;
      end
      chk("in_ready_idle", 32'(o_rdy(n4)), 32'd1);
      model(w, longint'(n4 ? {12'h0, a[3:0]} : a),
            longint'(n4 ? {12'h0, b[3:0]} : b), ci, su, es, eco, eov);
      drive(n4, 1'b1, a, b, ci, su);
      @(posedge clk); #1;
      drive(n4, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      chk("busy_after_accept", 32'(o_rdy(n4)), 32'd0);
      for (int i = 1; i <= ns; i++) begin
         chk("no_early_valid", 32'(o_val(n4)), 32'd0);
         @(posedge clk); #1;
      end
      chk("out_valid_latency", 32'(o_val(n4)), 32'd1);
      chk("sum", 32'(o_sum(n4)), 32'(es));
      chk("c_out", 32'(o_co(n4)), 32'(eco));
      chk("ovf", 32'(o_of(n4)), 32'(eov));
      if (hold > 0) begin
         if (n4) or4 = 1'b0; else or16 = 1'b0;
         drive(n4, 1'b1, ~a, a, ~ci, ~su);
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(o_val(n4)), 32'd1);
            chk("hold_sum", 32'(o_sum(n4)), 32'(es));
            chk("hold_c_out", 32'(o_co(n4)), 32'(eco));
            chk("hold_ovf", 32'(o_of(n4)), 32'(eov));
            chk("hold_in_ready", 32'(o_rdy(n4)), 32'd0);
         end
         drive(n4, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
         if (n4) or4 = 1'b1; else or16 = 1'b1;
      end
      @(posedge clk); #1;
      chk("back_to_idle_valid", 32'(o_val(n4)), 32'd0);
      chk("back_to_idle_ready", 32'(o_rdy(n4)), 32'd1);
   endtask

   initial begin
      #2;
      chk("rst_out_valid", 32'(ov16), 32'd0);
      chk("rst_sum", 32'(s16), 32'd0);
      chk("rst_c_out", 32'(co16), 32'd0);
      chk("rst_ovf", 32'(of16), 32'd0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", 32'(ir16), 32'd1);
      chk("rst_in_ready4", 32'(ir4), 32'd1);

      run_op(0, 16'h0005, 16'h0007, 1'b0, 1'b0, 0);
      run_op(0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);
      run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
      run_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 0);
      run_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 0);
      run_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 10);
      run_op(0, 16'hABCD, 16'h0F0F, 1'b1, 1'b1, 0);

      run_op(1, 16'h0005, 16'h0007, 1'b0, 1'b0, 0);
      run_op(1, 16'h000F, 16'h000A, 1'b1, 1'b0, 0);
      run_op(1, 16'h0007, 16'h0001, 1'b0, 1'b0, 2);

      for (int i = 0; i < 25; i++)
         run_op(0, 16'($urandom), 16'($urandom), 1'($urandom),
                1'($urandom), int'($urandom_range(0, 3)));
      for (int i = 0; i < 10; i++)
         run_op(1, 16'($urandom), 16'($urandom), 1'($urandom),
                1'($urandom), int'($urandom_range(0, 2)));

      // Abandon an op two cycles into RUN.
      drive(0, 1'b1, 16'h1111, 16'h1111, 1'b0, 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(ov16), 32'd0);
      chk("midrst_sum", 32'(s16), 32'd0);
      chk("midrst_c_out", 32'(co16), 32'd0);
      chk("midrst_ovf", 32'(of16), 32'd0);
      #4;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst_in_ready", 32'(ir16), 32'd1);
      for (int i = 0; i < 8; i++) begin
         chk("midrst_no_stale", 32'(ov16), 32'd0);
         @(posedge clk); #1;
      end
      run_op(0, 16'h0102, 16'h0304, 1'b0, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
